// File: rtl/w5300_rx_fetch.sv
// ---------------------------------------------------------------------------
// w5300_rx_fetch
//
// Receive-path engine for the W5300 host bus. On a start pulse it requests
// the shared bus, reads the socket's received-size register, and if data is
// pending drains one UDP packet (4-word header + payload) from the socket RX
// FIFO into the RX buffer RAM. A RECV command is always written to Sn_CR at
// the end so the socket buffer is freed, then the bus is released.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             single-cycle request, ignored while busy
//   bus_req, bus_gnt  handshake with the bus arbiter
//   addr              W5300 direct address (holds its last value when idle)
//   data_in           bus read data (big-endian: [15:8] is the earlier byte)
//   data_out, data_oe bus write data and its tri-state enable
//   cs_n, rd_n, we_n  W5300 strobes, active low, registered (glitch-free)
//   rx_wren           RAM write strobe, one pulse per stored payload word
//   rx_buffer_addr    RAM word address
//   rx_data           RAM write data
//   src_ip, src_port  sender address from the UDP header
//   rx_size           payload length in bytes
//   done              one-cycle completion pulse
//   busy_n            low from start acceptance until done
//   err_overflow      payload exceeded RAM capacity, sticky until next start
// ---------------------------------------------------------------------------
module w5300_rx_fetch #(
  parameter int SOCKET               = 0,
  parameter int RX_BUFFER_ADDR_WIDTH = 8,
  parameter int ACCESS_CYCLES        = 7,
  parameter int RECOVER_CYCLES       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            bus_req,
  input  logic                            bus_gnt,
  output logic [9:0]                      addr,
  input  logic [15:0]                     data_in,
  output logic [15:0]                     data_out,
  output logic                            data_oe,
  output logic                            cs_n,
  output logic                            rd_n,
  output logic                            we_n,
  output logic                            rx_wren,
  output logic [RX_BUFFER_ADDR_WIDTH-1:0] rx_buffer_addr,
  output logic [15:0]                     rx_data,
  output logic [31:0]                     src_ip,
  output logic [15:0]                     src_port,
  output logic [15:0]                     rx_size,
  output logic                            done,
  output logic                            busy_n,
  output logic                            err_overflow
);

  // Socket register map
  localparam logic [9:0] REG_BASE   = 10'(32'h200 + 32'h40 * SOCKET);
  localparam logic [9:0] ADDR_CR    = REG_BASE + 10'h002;
  localparam logic [9:0] ADDR_RSR_H = REG_BASE + 10'h028;
  localparam logic [9:0] ADDR_RSR_L = REG_BASE + 10'h02A;
  localparam logic [9:0] ADDR_FIFOR = REG_BASE + 10'h030;
  localparam logic [15:0] CMD_RECV  = 16'h0040;

  // Access phase counter: 0 = setup, 1..ACCESS = strobes low, rest = recovery
  localparam int CYC_W = $clog2(ACCESS_CYCLES + RECOVER_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LOW_END = CYC_W'(ACCESS_CYCLES);
  localparam logic [CYC_W-1:0] CYC_OE_END  = CYC_W'(ACCESS_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(ACCESS_CYCLES + RECOVER_CYCLES);

  localparam logic [32:0] RAM_WORDS = 33'd1 << RX_BUFFER_ADDR_WIDTH;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_REQ     = 4'd1;
  localparam logic [3:0] ST_RSR_H   = 4'd2;
  localparam logic [3:0] ST_RSR_L   = 4'd3;
  localparam logic [3:0] ST_HDR     = 4'd4;
  localparam logic [3:0] ST_DATA    = 4'd5;
  localparam logic [3:0] ST_CMD     = 4'd6;
  localparam logic [3:0] ST_RELEASE = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  logic [3:0]       st, st_nx;
  logic [CYC_W-1:0] cyc, cyc_nx;
  logic [1:0]       hdr_idx, hdr_idx_nx;
  logic [15:0]      word_idx, word_idx_nx;
  logic [15:0]      rsr_hi, rsr_lo;
  logic             acc_end;
  logic             rd_sample;
  logic             strobe_low_nx;
  logic [16:0]      n_words;
  logic             last_word;

  function automatic logic is_access(input logic [3:0] s);
    return (s == ST_RSR_H) || (s == ST_RSR_L) || (s == ST_HDR) ||
           (s == ST_DATA)  || (s == ST_CMD);
  endfunction

  function automatic logic is_read(input logic [3:0] s);
    return (s == ST_RSR_H) || (s == ST_RSR_L) || (s == ST_HDR) || (s == ST_DATA);
  endfunction

  function automatic logic [9:0] addr_of(input logic [3:0] s, input logic [9:0] cur);
    case (s)
      ST_RSR_H:        return ADDR_RSR_H;
      ST_RSR_L:        return ADDR_RSR_L;
      ST_HDR, ST_DATA: return ADDR_FIFOR;
      ST_CMD:          return ADDR_CR;
      default:         return cur;
    endcase
  endfunction

  // Payload word count, computed in 17 bits so 0xFFFF bytes does not wrap
  assign n_words   = ({1'b0, rx_size} + 17'd1) >> 1;
  assign last_word = ({1'b0, word_idx} + 17'd1) >= n_words;
  assign acc_end   = is_access(st) && (cyc == CYC_LAST);
  // Read data is captured on the edge that ends the last low cycle
  assign rd_sample = is_read(st) && (cyc == CYC_LOW_END);

  always_comb begin
    st_nx       = st;
    cyc_nx      = '0;
    hdr_idx_nx  = hdr_idx;
    word_idx_nx = word_idx;
    if (is_access(st)) begin
      cyc_nx = acc_end ? '0 : cyc + CYC_W'(1);
    end
    case (st)
      ST_IDLE:    if (start) st_nx = ST_REQ;
      ST_REQ:     if (bus_gnt) st_nx = ST_RSR_H;
      ST_RSR_H:   if (acc_end) st_nx = ST_RSR_L;
      ST_RSR_L: begin
        if (acc_end) begin
          // An empty socket still gets a RECV so the command sequence is uniform
          if ({rsr_hi, rsr_lo} == 32'd0) begin
            st_nx = ST_CMD;
          end else begin
            st_nx      = ST_HDR;
            hdr_idx_nx = 2'd0;
          end
        end
      end
      ST_HDR: begin
        if (acc_end) begin
          if (hdr_idx == 2'd3) begin
            word_idx_nx = 16'd0;
            st_nx       = (rx_size == 16'd0) ? ST_CMD : ST_DATA;
          end else begin
            hdr_idx_nx = hdr_idx + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (acc_end) begin
          if (last_word) st_nx = ST_CMD;
          else           word_idx_nx = word_idx + 16'd1;
        end
      end
      ST_CMD:     if (acc_end) st_nx = ST_RELEASE;
      ST_RELEASE: st_nx = ST_DONE;
      ST_DONE:    st_nx = ST_IDLE;
      default:    st_nx = ST_IDLE;
    endcase
  end

  assign strobe_low_nx = is_access(st_nx) && (cyc_nx != '0) && (cyc_nx <= CYC_LOW_END);

  // Control and bus outputs are registered from the next-state decode so the
  // strobes change only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= ST_IDLE;
      cyc            <= '0;
      hdr_idx        <= 2'd0;
      word_idx       <= 16'd0;
      rsr_hi         <= 16'd0;
      rsr_lo         <= 16'd0;
      bus_req        <= 1'b0;
      cs_n           <= 1'b1;
      rd_n           <= 1'b1;
      we_n           <= 1'b1;
      data_oe        <= 1'b0;
      addr           <= 10'd0;
      data_out       <= 16'd0;
      rx_wren        <= 1'b0;
      rx_buffer_addr <= '0;
      rx_data        <= 16'd0;
      src_ip         <= 32'd0;
      src_port       <= 16'd0;
      rx_size        <= 16'd0;
      done           <= 1'b0;
      busy_n         <= 1'b1;
      err_overflow   <= 1'b0;
    end else begin
      st       <= st_nx;
      cyc      <= cyc_nx;
      hdr_idx  <= hdr_idx_nx;
      word_idx <= word_idx_nx;

      bus_req <= (st_nx != ST_IDLE) && (st_nx != ST_RELEASE) && (st_nx != ST_DONE);
      busy_n  <= (st_nx == ST_IDLE);
      done    <= (st_nx == ST_DONE);

      cs_n    <= ~strobe_low_nx;
      rd_n    <= ~(strobe_low_nx && is_read(st_nx));
      we_n    <= ~(strobe_low_nx && (st_nx == ST_CMD));
      // Write data is driven from setup through the first recovery cycle
      data_oe <= (st_nx == ST_CMD) && (cyc_nx <= CYC_OE_END);

      if (is_access(st_nx) && (cyc_nx == '0)) begin
        addr <= addr_of(st_nx, addr);
      end
      if ((st_nx == ST_CMD) && (cyc_nx == '0)) begin
        data_out <= CMD_RECV;
      end

      if ((st == ST_IDLE) && start) begin
        err_overflow <= 1'b0;
      end

      rx_wren <= 1'b0;
      if (rd_sample) begin
        case (st)
          ST_RSR_H: rsr_hi <= data_in;
          ST_RSR_L: rsr_lo <= data_in;
          ST_HDR: begin
            case (hdr_idx)
              2'd0:    src_ip[31:16] <= data_in;
              2'd1:    src_ip[15:0]  <= data_in;
              2'd2:    src_port      <= data_in;
              default: rx_size       <= data_in;
            endcase
          end
          ST_DATA: begin
            // Words past RAM capacity are still read to drain the FIFO
            if ({17'd0, word_idx} < RAM_WORDS) begin
              rx_wren        <= 1'b1;
              rx_buffer_addr <= RX_BUFFER_ADDR_WIDTH'(word_idx);
              rx_data        <= data_in;
            end else begin
              err_overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if ((st == ST_RSR_L) && acc_end && ({rsr_hi, rsr_lo} == 32'd0)) begin
        rx_size <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_w5300_rx_fetch.sv
// ---------------------------------------------------------------------------
// tb_w5300_rx_fetch
//
// Bench for w5300_rx_fetch with a behavioural W5300 socket (RSR registers and
// RX FIFO), a simple arbiter with programmable grant delay, and a scoreboard:
// stimulus pushes expected RAM writes and completion records, and a monitor
// process checks them together with per-access strobe timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_w5300_rx_fetch;

  localparam int ACC = 7;
  localparam int REC = 3;
  localparam int AW  = 8;
  localparam logic [9:0] A_CR   = 10'h202;
  localparam logic [9:0] A_RSRH = 10'h228;
  localparam logic [9:0] A_RSRL = 10'h22A;
  localparam logic [9:0] A_FIFO = 10'h230;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bus_req;
  logic          bus_gnt = 1'b0;
  logic [9:0]    addr;
  logic [15:0]   data_in;
  logic [15:0]   data_out;
  logic          data_oe;
  logic          cs_n, rd_n, we_n;
  logic          rx_wren;
  logic [AW-1:0] rx_buffer_addr;
  logic [15:0]   rx_data;
  logic [31:0]   src_ip;
  logic [15:0]   src_port;
  logic [15:0]   rx_size;
  logic          done;
  logic          busy_n;
  logic          err_overflow;

  always #5 clk = ~clk;

  w5300_rx_fetch #(
    .SOCKET(0), .RX_BUFFER_ADDR_WIDTH(AW), .ACCESS_CYCLES(ACC), .RECOVER_CYCLES(REC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .cs_n(cs_n), .rd_n(rd_n), .we_n(we_n), .rx_wren(rx_wren),
    .rx_buffer_addr(rx_buffer_addr), .rx_data(rx_data), .src_ip(src_ip),
    .src_port(src_port), .rx_size(rx_size), .done(done), .busy_n(busy_n),
    .err_overflow(err_overflow)
  );

  // W5300 socket model
  logic [15:0] fifo_mem [0:511];
  int          fifo_ptr = 0;
  logic [31:0] rsr_val = 32'd0;

  always_comb begin
    data_in = 16'h0000;
    if (addr == A_RSRH)                         data_in = rsr_val[31:16];
    else if (addr == A_RSRL)                    data_in = rsr_val[15:0];
    else if (addr == A_FIFO && fifo_ptr < 512)  data_in = fifo_mem[fifo_ptr];
  end

  always @(posedge rd_n) begin
    if (!rst && addr == A_FIFO) fifo_ptr = fifo_ptr + 1;
  end

  // Arbiter: grants gnt_delay cycles after the request, holds until release
  int gnt_delay = 0;
  int gnt_cnt = 0;
  always @(posedge clk) begin
    if (rst || !bus_req) begin
      bus_gnt <= 1'b0;
      gnt_cnt <= 0;
    end else if (gnt_cnt >= gnt_delay) begin
      bus_gnt <= 1'b1;
    end else begin
      gnt_cnt <= gnt_cnt + 1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;
  typedef struct {
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] size;
    logic        err;
    int          reads;
    int          writes;
    int          lat;
  } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  bit          prev_cs = 1'b1;
  int          lowcnt = 0, highcnt = 0, acc_cnt = 0;
  int          mon_fifo_reads = 0, mon_cmd_writes = 0, lat = 0;
  bit          gnt_seen = 1'b0, acc_rd = 1'b0, last_wr = 1'b0;
  logic [9:0]  acc_addr = 10'd0;

  always @(negedge clk) begin
    wr_t   we;
    done_t de;
    if (rst) begin
      prev_cs = 1'b1; lowcnt = 0; highcnt = 0; acc_cnt = 0;
      mon_fifo_reads = 0; mon_cmd_writes = 0; lat = 0;
      gnt_seen = 1'b0; last_wr = 1'b0;
    end else begin
      if (gnt_seen) lat++;
      else if (bus_gnt && bus_req) begin gnt_seen = 1'b1; lat = 0; end

      if (bus_req && !bus_gnt) chk("quiet_before_gnt", {cs_n, rd_n, we_n, data_oe}, 4'b1110);

      if (!cs_n) begin
        if (prev_cs) begin
          if (acc_cnt == 0) chk("setup_first", lat, 2);
          else              chk("recover_plus_setup", highcnt, REC + 1);
          lowcnt = 0; acc_addr = addr; acc_rd = !rd_n;
        end
        lowcnt++;
        chk("one_strobe", rd_n ^ we_n, 1);
        chk("addr_stable", addr, acc_addr);
        if (!we_n) begin
          chk("cmd_addr", addr, A_CR);
          chk("cmd_data", {data_oe, data_out}, {1'b1, 16'h0040});
        end
      end else begin
        if (!prev_cs) begin
          chk("low_len", lowcnt, ACC);
          acc_cnt++;
          if (acc_rd && acc_addr == A_FIFO) mon_fifo_reads++;
          if (!acc_rd) mon_cmd_writes++;
          last_wr = !acc_rd;
          highcnt = 0;
        end
        highcnt++;
        chk("strobes_high", {rd_n, we_n}, 2'b11);
        if (last_wr && highcnt == 1) chk("oe_recover1", data_oe, 1);
        if (last_wr && highcnt == 2) chk("oe_off", data_oe, 0);
      end
      prev_cs = cs_n;

      if (rx_wren) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", rx_buffer_addr, rx_data);
        end else begin
          we = wr_q.pop_front();
          chk("wr_addr", rx_buffer_addr, we.a);
          chk("wr_data", rx_data, we.d);
        end
      end

      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: src_ip 0x%0h", src_ip);
        end else begin
          de = done_q.pop_front();
          chk("src_ip", src_ip, de.ip);
          chk("src_port", src_port, de.port);
          chk("rx_size", rx_size, de.size);
          chk("err_overflow", err_overflow, de.err);
          chk("fifo_reads", mon_fifo_reads, de.reads);
          chk("cmd_writes", mon_cmd_writes, de.writes);
          chk("gnt_to_done", lat, de.lat);
        end
        acc_cnt = 0; mon_fifo_reads = 0; mon_cmd_writes = 0;
        gnt_seen = 1'b0; lat = 0; last_wr = 1'b0;
      end
    end
  end

  // Stimulus helpers
  task automatic load_hdr(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] size);
    fifo_ptr    = 0;
    fifo_mem[0] = ip[31:16];
    fifo_mem[1] = ip[15:0];
    fifo_mem[2] = port;
    fifo_mem[3] = size;
    rsr_val     = 32'(size) + 32'd8;
  endtask

  task automatic add_word(input int k, input logic [15:0] d, input bit expect_wr);
    wr_t w;
    fifo_mem[4 + k] = d;
    if (expect_wr) begin
      w.a = AW'(k);
      w.d = d;
      wr_q.push_back(w);
    end
  endtask

  task automatic exp_done(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] size,
                          input logic err, input int reads, input int lt);
    done_t e;
    e.ip = ip; e.port = port; e.size = size; e.err = err;
    e.reads = reads; e.writes = 1; e.lat = lt;
    done_q.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", {bus_req, cs_n, rd_n, we_n, data_oe, rx_wren, done, busy_n, err_overflow},
        9'b0_111_0_0_0_1_0);
    chk("rst_addr", addr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_rx_buffer_addr", rx_buffer_addr, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_src", {src_ip, src_port, rx_size}, 64'd0);
  endtask

  task automatic run_txn(input int delay, input bit poke_busy, input bit start_at_done);
    int n;
    gnt_delay = delay;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("bus_req_rise", bus_req, 1);
    chk("busy_n_fall", busy_n, 0);
    for (int i = 0; i < delay; i++) begin
      chk("req_held_no_gnt", {bus_req, bus_gnt, cs_n}, 3'b101);
      @(negedge clk);
    end
    n = 0;
    while (done !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
      start = (poke_busy && n == 30);
    end
    start = 1'b0;
    if (n >= 10000) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end else if (start_at_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("idle_after", {bus_req, busy_n, cs_n}, 3'b011);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Empty socket
    rsr_val = 32'd0; fifo_ptr = 0;
    exp_done(32'd0, 16'd0, 16'd0, 1'b0, 0, 35);
    run_txn(0, 1'b0, 1'b0);

    // 192.168.111.1:7000, 6 bytes; extra start while busy must be dropped
    load_hdr(32'hC0A86F01, 16'h1B58, 16'd6);
    add_word(0, 16'h1111, 1'b1);
    add_word(1, 16'h2222, 1'b1);
    add_word(2, 16'h3333, 1'b1);
    exp_done(32'hC0A86F01, 16'h1B58, 16'd6, 1'b0, 7, 112);
    run_txn(0, 1'b1, 1'b0);

    // Odd length 5 with grant withheld 20 cycles; padding byte kept
    load_hdr(32'h0A000005, 16'h1234, 16'd5);
    add_word(0, 16'hABCD, 1'b1);
    add_word(1, 16'h1234, 1'b1);
    add_word(2, 16'h56EF, 1'b1);
    exp_done(32'h0A000005, 16'h1234, 16'd5, 1'b0, 7, 112);
    run_txn(20, 1'b0, 1'b0);

    // Empty socket again: header fields hold, rx_size cleared; start at done dropped
    rsr_val = 32'd0; fifo_ptr = 0;
    exp_done(32'h0A000005, 16'h1234, 16'd0, 1'b0, 0, 35);
    run_txn(0, 1'b0, 1'b1);

    // Overflow: 600 bytes = 300 words, only 256 stored
    load_hdr(32'h0A0B0C0D, 16'h0050, 16'd600);
    for (int k = 0; k < 300; k++) add_word(k, 16'hA000 + 16'(k), k < 256);
    exp_done(32'h0A0B0C0D, 16'h0050, 16'd600, 1'b1, 304, 3379);
    run_txn(0, 1'b0, 1'b0);
    chk("ovf_last_addr", rx_buffer_addr, 8'hFF);
    chk("ovf_sticky", err_overflow, 1);

    // Next start clears err_overflow
    rsr_val = 32'd0; fifo_ptr = 0;
    exp_done(32'h0A0B0C0D, 16'h0050, 16'd0, 1'b0, 0, 35);
    run_txn(0, 1'b0, 1'b0);

    // Reset during DATA word 2
    load_hdr(32'hC0A80001, 16'h0BB8, 16'd8);
    for (int k = 0; k < 4; k++) add_word(k, 16'h7000 + 16'(k), k < 2);
    gnt_delay = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(mon_fifo_reads == 6 && !cs_n) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL reach_word2_timeout: fifo reads %0d", mon_fifo_reads);
    end
    #1 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wr_q_drained", wr_q.size(), 0);

    // Clean full sequence after reset
    load_hdr(32'hC0A80002, 16'h0FA0, 16'd6);
    add_word(0, 16'h0101, 1'b1);
    add_word(1, 16'h0202, 1'b1);
    add_word(2, 16'h0303, 1'b1);
    exp_done(32'hC0A80002, 16'h0FA0, 16'd6, 1'b0, 7, 112);
    run_txn(0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
